lif_neuron_array: RTL and testbench

Time-multiplexed array of N leaky-integrate-and-fire neurons. It is the parametrised successor of the single-neuron LSNN datapath in the TinyTapeout top. Weighted input events accumulate per neuron between timesteps. A `step` pulse sweeps all neurons once, one neuron per cycle, applying leak, integration, threshold, reset and refractory logic. It then publishes a spike vector. The block sits behind the top-level pin wrapper, which drives events and configuration from ui_in/uio_in.

---
 rtl/lif_neuron_array.sv | 226 ++++++++++++++++++++++
 tb/tb_lif_neuron_array.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky-integrate-and-fire neurons swept one neuron per cycle on each step pulse.
// Optional per-neuron threshold adaptation is enabled by defining LIF_ADAPT_THRESH_EN.
module lif_neuron_array #(
    parameter int N_NEURONS = 8,
    parameter int V_WIDTH   = 8,
    parameter int REF_WIDTH = 2,
    parameter int ADAPT_INC = 4,
    localparam int IDX_W    = $clog2(N_NEURONS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IDX_W-1:0]          in_idx,
    input  logic signed [V_WIDTH-1:0] in_weight,
    input  logic                      step,
    input  logic [V_WIDTH-1:0]        threshold,
    input  logic [2:0]                leak_shift,
    input  logic [REF_WIDTH-1:0]      refrac,
    output logic                      busy,
    output logic [N_NEURONS-1:0]      spikes,
    output logic                      spike_valid,
    output logic [IDX_W:0]            spike_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(N_NEURONS - 1);
    localparam logic [IDX_W-1:0]     PTR_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [REF_WIDTH-1:0] REF_ONE  = {{(REF_WIDTH-1){1'b0}}, 1'b1};

    // Signed saturating add used for the per-neuron input accumulators.
    function automatic logic [V_WIDTH-1:0] sat_add(input logic [V_WIDTH-1:0] a,
                                                   input logic [V_WIDTH-1:0] b);
        logic [V_WIDTH:0] s;
        s = {a[V_WIDTH-1], a} + {b[V_WIDTH-1], b};
        if (s[V_WIDTH] != s[V_WIDTH-1]) begin
            sat_add = s[V_WIDTH] ? {1'b1, {(V_WIDTH-1){1'b0}}} : {1'b0, {(V_WIDTH-1){1'b1}}};
        end else begin
            sat_add = s[V_WIDTH-1:0];
        end
    endfunction

    function automatic logic [IDX_W:0] popcount(input logic [N_NEURONS-1:0] x);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            c = c + {{IDX_W{1'b0}}, x[i]};
        end
        return c;
    endfunction

    logic [1:0]              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [V_WIDTH-1:0]      thr_q;
    logic [2:0]              leak_q;
    logic [REF_WIDTH-1:0]    refrac_q;
    logic [V_WIDTH-1:0]      v_q   [N_NEURONS];
    logic [V_WIDTH-1:0]      acc_q [N_NEURONS];
    logic [REF_WIDTH-1:0]    ref_q [N_NEURONS];
    logic [N_NEURONS-1:0]    shadow_q;
    logic [N_NEURONS-1:0]    spikes_q;
    logic                    spike_valid_q;
    logic [IDX_W:0]          spike_count_q;

    logic                    in_ready_s;
    logic                    idx_ok_s;
    logic                    ev_fire_s;
    logic                    step_go_s;
    logic [V_WIDTH-1:0]      acc_ev_s;
    logic [V_WIDTH-1:0]      v_cur_s;
    logic [V_WIDTH-1:0]      acc_cur_s;
    logic [REF_WIDTH-1:0]    ref_cur_s;
    logic [V_WIDTH-1:0]      leak_s;
    logic signed [V_WIDTH+1:0] sum_s;
    logic [V_WIDTH-1:0]      v_lin_s;
    logic [V_WIDTH-1:0]      thr_eff_s;
    logic                    spike_s;

    assign in_ready    = in_ready_s;
    assign busy        = (state_q != ST_IDLE);
    assign spikes      = spikes_q;
    assign spike_count = spike_count_q;
    assign spike_valid = spike_valid_q & ena;

    // Event handshake and step launch qualifiers.
    always_comb begin
        in_ready_s = (state_q == ST_IDLE) && ena;
        idx_ok_s   = (32'(in_idx) < N_NEURONS);
        ev_fire_s  = in_valid && in_ready_s && idx_ok_s;
        step_go_s  = (state_q == ST_IDLE) && ena && step;
        acc_ev_s   = sat_add(acc_q[in_idx], in_weight);
    end

    // Sweep controller next-state.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (step) begin
                    state_d = ST_SWEEP;
                    ptr_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (ptr_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    ptr_d = ptr_q + PTR_ONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef LIF_ADAPT_THRESH_EN
    logic [V_WIDTH-1:0] a_q [N_NEURONS];
    logic [V_WIDTH-1:0] a_cur_s;
    logic [V_WIDTH:0]   thr_sum_s;
    logic [V_WIDTH:0]   a_sum_s;
    logic [V_WIDTH-1:0] a_inc_s;
    logic [V_WIDTH-1:0] a_dec_s;

    // Effective threshold and adaptation update candidates for the current neuron.
    always_comb begin
        a_cur_s   = a_q[ptr_q];
        thr_sum_s = {1'b0, thr_q} + {1'b0, a_cur_s};
        thr_eff_s = thr_sum_s[V_WIDTH] ? {V_WIDTH{1'b1}} : thr_sum_s[V_WIDTH-1:0];
        a_sum_s   = {1'b0, a_cur_s} + (V_WIDTH+1)'(ADAPT_INC);
        a_inc_s   = a_sum_s[V_WIDTH] ? {V_WIDTH{1'b1}} : a_sum_s[V_WIDTH-1:0];
        a_dec_s   = a_cur_s - (a_cur_s >> 2);
    end

    // Adaptation registers: bumped on spike, decayed on quiet update, held while refractory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                a_q[i] <= '0;
            end
        end else if (ena && (state_q == ST_SWEEP) && (ref_cur_s == '0)) begin
            a_q[ptr_q] <= spike_s ? a_inc_s : a_dec_s;
        end
    end
`else
    // Without adaptation the latched threshold is used directly.
    always_comb begin
        thr_eff_s = thr_q;
    end
`endif

    // Leak/integrate/fire datapath for the neuron under the sweep pointer.
    always_comb begin
        v_cur_s   = v_q[ptr_q];
        acc_cur_s = acc_q[ptr_q];
        ref_cur_s = ref_q[ptr_q];
        leak_s    = v_cur_s >> leak_q;
        sum_s     = $signed({2'b00, v_cur_s}) - $signed({2'b00, leak_s})
                  + $signed({{2{acc_cur_s[V_WIDTH-1]}}, acc_cur_s});
        if (sum_s[V_WIDTH+1]) begin
            v_lin_s = '0;
        end else if (sum_s[V_WIDTH]) begin
            v_lin_s = {V_WIDTH{1'b1}};
        end else begin
            v_lin_s = sum_s[V_WIDTH-1:0];
        end
        spike_s = (ref_cur_s == '0) && (v_lin_s >= thr_eff_s);
    end

    // Neuron state, configuration latches and published spike outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            thr_q         <= '0;
            leak_q        <= 3'd0;
            refrac_q      <= '0;
            shadow_q      <= '0;
            spikes_q      <= '0;
            spike_valid_q <= 1'b0;
            spike_count_q <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v_q[i]   <= '0;
                acc_q[i] <= '0;
                ref_q[i] <= '0;
            end
        end else if (ena) begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            spike_valid_q <= (state_q == ST_DONE);
            if (step_go_s) begin
                thr_q    <= threshold;
                leak_q   <= leak_shift;
                refrac_q <= refrac;
                shadow_q <= '0;
            end
            if (ev_fire_s) begin
                acc_q[in_idx] <= acc_ev_s;
            end
            if (state_q == ST_SWEEP) begin
                acc_q[ptr_q]    <= '0;
                shadow_q[ptr_q] <= spike_s;
                if (ref_cur_s != '0) begin
                    ref_q[ptr_q] <= ref_cur_s - REF_ONE;
                    v_q[ptr_q]   <= '0;
                end else if (spike_s) begin
                    ref_q[ptr_q] <= refrac_q;
                    v_q[ptr_q]   <= '0;
                end else begin
                    v_q[ptr_q]   <= v_lin_s;
                end
            end
            if (state_q == ST_DONE) begin
                spikes_q      <= shadow_q;
                spike_count_q <= popcount(shadow_q);
            end
        end
    end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed self-checking bench for lif_neuron_array (N=8 main instance, N=6 instance for out-of-range indices).
module tb_lif_neuron_array;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_idx;
    logic [7:0] in_weight;
    logic       step;
    logic [7:0] threshold;
    logic [2:0] leak_shift;
    logic [1:0] refrac;
    logic       busy;
    logic [7:0] spikes;
    logic       spike_valid;
    logic [3:0] spike_count;

    logic       in_valid6;
    logic       in_ready6;
    logic [2:0] in_idx6;
    logic [7:0] in_weight6;
    logic       step6;
    logic       busy6;
    logic [5:0] spikes6;
    logic       spike_valid6;
    logic [3:0] spike_count6;

    int n_compared;
    int n_mismatched;

    lif_neuron_array #(.N_NEURONS(8), .V_WIDTH(8), .REF_WIDTH(2), .ADAPT_INC(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_weight(in_weight),
        .step(step), .threshold(threshold), .leak_shift(leak_shift), .refrac(refrac),
        .busy(busy), .spikes(spikes), .spike_valid(spike_valid), .spike_count(spike_count)
    );

    lif_neuron_array #(.N_NEURONS(6), .V_WIDTH(8), .REF_WIDTH(2), .ADAPT_INC(4)) dut6 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .in_valid(in_valid6), .in_ready(in_ready6), .in_idx(in_idx6), .in_weight(in_weight6),
        .step(step6), .threshold(threshold), .leak_shift(leak_shift), .refrac(refrac),
        .busy(busy6), .spikes(spikes6), .spike_valid(spike_valid6), .spike_count(spike_count6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_event(input logic [2:0] idx, input logic [7:0] w);
        in_valid  = 1'b1;
        in_idx    = idx;
        in_weight = w;
        @(posedge clk); #1;
        in_valid  = 1'b0;
    endtask

    task automatic run_step(input logic [7:0] thr, input logic [2:0] ls, input logic [1:0] rf,
                            output int cyc);
        threshold  = thr;
        leak_shift = ls;
        refrac     = rf;
        step       = 1'b1;
        @(posedge clk); #1;
        step     = 1'b0;
        in_valid = 1'b0;
        cyc = 0;
        while (spike_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_compared++;
        if (cyc >= 40) begin
            n_mismatched++;
            $display("FAIL step_timeout: got no spike_valid within %0d cycles, required within 9", cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_compared++;
        if (busy !== 1'b0) begin n_mismatched++; $display("FAIL reset_busy_in_reset: got %b required 0", busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_compared++;
        if (spikes !== 8'h00) begin n_mismatched++; $display("FAIL reset_spikes: got %h required 00", spikes); end
        n_compared++;
        if (spike_count !== 4'd0) begin n_mismatched++; $display("FAIL reset_count: got %0d required 0", spike_count); end
        n_compared++;
        if (spike_valid !== 1'b0) begin n_mismatched++; $display("FAIL reset_valid: got %b required 0", spike_valid); end
        n_compared++;
        if (busy !== 1'b0) begin n_mismatched++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_compared++;
        if (in_ready !== 1'b1) begin n_mismatched++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    endtask

    task automatic test_integrate();
        int cyc;
        send_event(3'd3, 8'd60);
        run_step(8'd100, 3'd2, 2'd0, cyc);
        n_compared++;
        if (spikes !== 8'h00) begin n_mismatched++; $display("FAIL integ1_spikes: got %h required 00", spikes); end
        n_compared++;
        if (dut.v_q[3] !== 8'd60) begin n_mismatched++; $display("FAIL integ1_v3: got %0d required 60", dut.v_q[3]); end
        send_event(3'd3, 8'd60);
        run_step(8'd100, 3'd2, 2'd0, cyc);
        n_compared++;
        if (cyc !== 9) begin n_mismatched++; $display("FAIL integ2_latency: got %0d required 9", cyc); end
        n_compared++;
        if (spikes !== 8'h08) begin n_mismatched++; $display("FAIL integ2_spikes: got %h required 08", spikes); end
        n_compared++;
        if (spike_count !== 4'd1) begin n_mismatched++; $display("FAIL integ2_count: got %0d required 1", spike_count); end
        @(posedge clk); #1;
        n_compared++;
        if (spike_valid !== 1'b0) begin n_mismatched++; $display("FAIL integ2_pulse_width: got %b required 0", spike_valid); end
        n_compared++;
        if (spikes !== 8'h08) begin n_mismatched++; $display("FAIL integ2_spikes_hold: got %h required 08", spikes); end
    endtask

    task automatic test_refractory();
        int cyc;
        logic [7:0] exp_sp [4];
        exp_sp[0] = 8'h08; exp_sp[1] = 8'h00; exp_sp[2] = 8'h00; exp_sp[3] = 8'h08;
        for (int k = 0; k < 4; k++) begin
            send_event(3'd3, 8'd127);
            run_step(8'd100, 3'd2, 2'd2, cyc);
            n_compared++;
            if (spikes !== exp_sp[k]) begin
                n_mismatched++;
                $display("FAIL refrac_step%0d: got %h required %h", k, spikes, exp_sp[k]);
            end
        end
        // Zero threshold: everyone fires except neuron 3, still refractory.
        for (int k = 0; k < 2; k++) begin
            run_step(8'd0, 3'd0, 2'd0, cyc);
            n_compared++;
            if (spikes !== 8'hF7) begin n_mismatched++; $display("FAIL thr0_spikes%0d: got %h required f7", k, spikes); end
            n_compared++;
            if (spike_count !== 4'd7) begin n_mismatched++; $display("FAIL thr0_count%0d: got %0d required 7", k, spike_count); end
        end
    endtask

    task automatic test_saturation();
        int cyc;
        send_event(3'd5, 8'd127);
        send_event(3'd5, 8'd127);
        n_compared++;
        if (dut.acc_q[5] !== 8'h7F) begin n_mismatched++; $display("FAIL sat_pos_acc5: got %h required 7f", dut.acc_q[5]); end
        send_event(3'd0, 8'h80);
        send_event(3'd0, 8'h80);
        n_compared++;
        if (dut.acc_q[0] !== 8'h80) begin n_mismatched++; $display("FAIL sat_neg_acc0: got %h required 80", dut.acc_q[0]); end
        run_step(8'd100, 3'd0, 2'd0, cyc);
        n_compared++;
        if (spikes !== 8'h20) begin n_mismatched++; $display("FAIL sat_spikes: got %h required 20", spikes); end
        n_compared++;
        if (dut.v_q[0] !== 8'd0) begin n_mismatched++; $display("FAIL sat_v0: got %0d required 0", dut.v_q[0]); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int pulses;
        send_event(3'd2, 8'd120);
        threshold = 8'd100; leak_shift = 3'd2; refrac = 2'd0;
        step = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_idx = 3'd4; in_weight = 8'd127;
        n_compared++;
        if (in_ready !== 1'b0) begin n_mismatched++; $display("FAIL busy_in_ready: got %b required 0", in_ready); end
        n_compared++;
        if (busy !== 1'b1) begin n_mismatched++; $display("FAIL busy_flag: got %b required 1", busy); end
        pulses = 0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            if (spike_valid === 1'b1) pulses++;
            if (k == 4) begin step = 1'b0; in_valid = 1'b0; end
        end
        n_compared++;
        if (pulses !== 1) begin n_mismatched++; $display("FAIL step_while_busy_pulses: got %0d required 1", pulses); end
        n_compared++;
        if (spikes !== 8'h04) begin n_mismatched++; $display("FAIL busy_spikes: got %h required 04", spikes); end
        n_compared++;
        if (dut.acc_q[4] !== 8'h00) begin n_mismatched++; $display("FAIL busy_event_dropped: got %h required 00", dut.acc_q[4]); end
        in_valid = 1'b1; in_idx = 3'd6; in_weight = 8'd110;
        run_step(8'd100, 3'd2, 2'd0, cyc);
        n_compared++;
        if (spikes !== 8'h40) begin n_mismatched++; $display("FAIL same_cycle_spikes: got %h required 40", spikes); end
        n_compared++;
        if (cyc !== 9) begin n_mismatched++; $display("FAIL same_cycle_latency: got %0d required 9", cyc); end
    endtask

    task automatic test_enable();
        int cyc;
        ena = 1'b0; step = 1'b1; threshold = 8'd100; leak_shift = 3'd2; refrac = 2'd0;
        repeat (2) begin @(posedge clk); #1; end
        step = 1'b0;
        n_compared++;
        if (busy !== 1'b0) begin n_mismatched++; $display("FAIL ena_low_step_busy: got %b required 0", busy); end
        n_compared++;
        if (in_ready !== 1'b0) begin n_mismatched++; $display("FAIL ena_low_in_ready: got %b required 0", in_ready); end
        ena = 1'b1;
        send_event(3'd1, 8'd120);
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        ena  = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_compared++;
        if (busy !== 1'b1) begin n_mismatched++; $display("FAIL ena_low_freeze_busy: got %b required 1", busy); end
        ena = 1'b1;
        cyc = 3;
        while (spike_valid !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        n_compared++;
        if (cyc !== 12) begin n_mismatched++; $display("FAIL ena_stall_latency: got %0d required 12", cyc); end
        n_compared++;
        if (spikes !== 8'h02) begin n_mismatched++; $display("FAIL ena_stall_spikes: got %h required 02", spikes); end
        ena = 1'b0;
        #1;
        n_compared++;
        if (spike_valid !== 1'b0) begin n_mismatched++; $display("FAIL ena_low_valid_mask: got %b required 0", spike_valid); end
        ena = 1'b1;
    endtask

    task automatic test_reset_mid_sweep();
        int cyc;
        send_event(3'd7, 8'd120);
        threshold = 8'd100; leak_shift = 3'd0; refrac = 2'd0;
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_compared++;
        if (spikes !== 8'h00) begin n_mismatched++; $display("FAIL midrst_spikes: got %h required 00", spikes); end
        n_compared++;
        if (spike_count !== 4'd0) begin n_mismatched++; $display("FAIL midrst_count: got %0d required 0", spike_count); end
        n_compared++;
        if (busy !== 1'b0) begin n_mismatched++; $display("FAIL midrst_busy: got %b required 0", busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_step(8'd100, 3'd0, 2'd0, cyc);
        n_compared++;
        if (spikes !== 8'h00) begin n_mismatched++; $display("FAIL midrst_acc_cleared: got %h required 00", spikes); end
    endtask

    task automatic test_out_of_range();
        int cyc;
        in_valid6 = 1'b1; in_weight6 = 8'd100;
        in_idx6 = 3'd7; @(posedge clk); #1;
        in_idx6 = 3'd6; @(posedge clk); #1;
        in_idx6 = 3'd2; @(posedge clk); #1;
        in_valid6 = 1'b0;
        threshold = 8'd100; leak_shift = 3'd0; refrac = 2'd0;
        step6 = 1'b1;
        @(posedge clk); #1;
        step6 = 1'b0;
        cyc = 0;
        while (spike_valid6 !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
        n_compared++;
        if (cyc !== 7) begin n_mismatched++; $display("FAIL oor_latency_n6: got %0d required 7", cyc); end
        n_compared++;
        if (spikes6 !== 6'b000100) begin n_mismatched++; $display("FAIL oor_spikes_n6: got %b required 000100", spikes6); end
        n_compared++;
        if (spike_count6 !== 4'd1) begin n_mismatched++; $display("FAIL oor_count_n6: got %0d required 1", spike_count6); end
    endtask

`ifdef LIF_ADAPT_THRESH_EN
    task automatic test_adapt();
        int cyc;
        send_event(3'd1, 8'd120);
        run_step(8'd100, 3'd0, 2'd0, cyc);
        n_compared++;
        if (spikes !== 8'h02) begin n_mismatched++; $display("FAIL adapt_first_spike: got %h required 02", spikes); end
        n_compared++;
        if (dut.a_q[1] !== 8'd4) begin n_mismatched++; $display("FAIL adapt_a1_inc: got %0d required 4", dut.a_q[1]); end
        send_event(3'd1, 8'd100);
        run_step(8'd100, 3'd0, 2'd0, cyc);
        n_compared++;
        if (spikes !== 8'h00) begin n_mismatched++; $display("FAIL adapt_raised_thr: got %h required 00", spikes); end
        n_compared++;
        if (dut.a_q[1] !== 8'd3) begin n_mismatched++; $display("FAIL adapt_a1_decay: got %0d required 3", dut.a_q[1]); end
    endtask
`endif

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst_n = 1'b0; ena = 1'b1;
        in_valid = 1'b0; in_idx = 3'd0; in_weight = 8'd0; step = 1'b0;
        in_valid6 = 1'b0; in_idx6 = 3'd0; in_weight6 = 8'd0; step6 = 1'b0;
        threshold = 8'd0; leak_shift = 3'd0; refrac = 2'd0;
        test_reset();
`ifdef LIF_ADAPT_THRESH_EN
        test_adapt();
`else
        test_integrate();
        test_refractory();
        test_saturation();
        test_back_to_back();
        test_enable();
        test_reset_mid_sweep();
        test_out_of_range();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
